// File: rtl/udar_scan_ctrl_if.sv
// UDAR scan controller bus: UART RX/TX, servo PWM load and ranging handshake.
// master = sequencer side, slave = surrounding cores.
interface udar_scan_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  servo_x;
    logic [7:0]  servo_y;
    logic        servo_load;
    logic        meas_start;
    logic        meas_done;
    logic [23:0] meas_width;
    logic        busy;
    logic        err;
    logic        ovr;

    modport master (
        input  rx_data, rx_valid, tx_busy, meas_done, meas_width,
        output tx_data, tx_start, servo_x, servo_y, servo_load, meas_start,
               busy, err, ovr
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, meas_done, meas_width,
        input  tx_data, tx_start, servo_x, servo_y, servo_load, meas_start,
               busy, err, ovr
    );
endinterface

// File: rtl/udar_scan_ctrl.sv
// UDAR command sequencer: cmd/x/y frames -> servo move, settle, optional ranging, UART reply.
// Optional macro UDAR_SCAN_CLAMP_EN clamps positions to [ANGLE_MIN, ANGLE_MAX].
module udar_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1000000,
    parameter int unsigned ECHO_TIMEOUT  = 1900000,
    parameter int unsigned GAP_CYCLES    = 500000,
    parameter logic [7:0]  SERVO_RESET   = 8'h80,
    parameter logic [7:0]  ANGLE_MIN     = 8'd20,
    parameter logic [7:0]  ANGLE_MAX     = 8'd230
) (
    input  logic            clk,
    input  logic            rst_n,
    udar_scan_ctrl_if.master bus
);
    localparam int unsigned CNT_MAX0 = (SETTLE_CYCLES > ECHO_TIMEOUT) ? SETTLE_CYCLES : ECHO_TIMEOUT;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > GAP_CYCLES) ? CNT_MAX0 : GAP_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, GET_X, GET_Y, MOVE, SETTLE, TRIG, WAIT_ECHO, REPLY
    } state_t;

`ifdef UDAR_SCAN_CLAMP_EN
    function automatic logic [7:0] f_pos(input logic [7:0] v);
        if (v < ANGLE_MIN)      return ANGLE_MIN;
        else if (v > ANGLE_MAX) return ANGLE_MAX;
        else                    return v;
    endfunction
`else
    function automatic logic [7:0] f_pos(input logic [7:0] v);
        return v;
    endfunction
    logic w_unused_angle;
    assign w_unused_angle = ^{ANGLE_MIN, ANGLE_MAX};
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_meas;
    logic [7:0]       r_x;
    logic [31:0]      r_reply;
    logic [2:0]       r_left;
    logic             r_guard;
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic [7:0]       r_servo_x;
    logic [7:0]       r_servo_y;
    logic             r_servo_load;
    logic             r_meas_start;
    logic             r_busy;
    logic             r_err;
    logic             r_ovr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cmd_meas   <= 1'b0;
            r_x          <= '0;
            r_reply      <= '0;
            r_left       <= '0;
            r_guard      <= 1'b0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_servo_x    <= SERVO_RESET;
            r_servo_y    <= SERVO_RESET;
            r_servo_load <= 1'b0;
            r_meas_start <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_servo_load <= 1'b0;
            r_meas_start <= 1'b0;
            r_err        <= 1'b0;
            if (bus.rx_valid && !(r_state inside {IDLE, GET_X, GET_Y}))
                r_ovr <= 1'b1;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (bus.rx_valid) begin
                        if (bus.rx_data == 8'h0F || bus.rx_data == 8'hF0) begin
                            r_cmd_meas <= (bus.rx_data == 8'h0F);
                            r_busy     <= 1'b1;
                            r_state    <= GET_X;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                GET_X, GET_Y: begin
                    if (bus.rx_valid) begin
                        r_cnt <= '0;
                        if (r_state == GET_X) begin
                            r_x     <= bus.rx_data;
                            r_state <= GET_Y;
                        end else begin
                            r_servo_x    <= f_pos(r_x);
                            r_servo_y    <= f_pos(bus.rx_data);
                            r_servo_load <= 1'b1;
                            r_state      <= MOVE;
                        end
                    end else if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                MOVE: begin
                    r_cnt   <= '0;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        r_cnt <= '0;
                        if (r_cmd_meas) begin
                            r_meas_start <= 1'b1;
                            r_state      <= TRIG;
                        end else begin
                            r_reply <= {8'hAC, 24'h0};
                            r_left  <= 3'd1;
                            r_guard <= 1'b0;
                            r_state <= REPLY;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TRIG: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_ECHO;
                end
                WAIT_ECHO: begin
                    // A done strobe in the expiry cycle is checked first, so it wins.
                    if (bus.meas_done) begin
                        r_cnt   <= '0;
                        r_reply <= {8'hA5, bus.meas_width};
                        r_left  <= 3'd4;
                        r_guard <= 1'b0;
                        r_state <= REPLY;
                    end else if (r_cnt == CNT_W'(ECHO_TIMEOUT - 1)) begin
                        r_cnt   <= '0;
                        r_reply <= {8'hE1, 24'h0};
                        r_left  <= 3'd4;
                        r_guard <= 1'b0;
                        r_state <= REPLY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                REPLY: begin
                    // The guard cycle after the last byte also lets busy drop one cycle after it.
                    if (r_guard) begin
                        r_guard <= 1'b0;
                        if (r_left == 3'd0) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (r_left != 3'd0 && !bus.tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_reply[31:24];
                        r_reply    <= {r_reply[23:0], 8'h00};
                        r_left     <= r_left - 1'b1;
                        r_guard    <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.tx_start   = r_tx_start;
    assign bus.servo_x    = r_servo_x;
    assign bus.servo_y    = r_servo_y;
    assign bus.servo_load = r_servo_load;
    assign bus.meas_start = r_meas_start;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
    assign bus.ovr        = r_ovr;
endmodule
